// File: rtl/audio_ctrl_pkg.sv
// audio_ctrl_pkg: calibration state encoding and default timing constants
package audio_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE_DC = 3'd1,
    OFFSET    = 3'd2,
    SETTLE_IR = 3'd3,
    IMPULSE   = 3'd4,
    RUN       = 3'd5,
    ERROR     = 3'd6
  } cal_state_t;
  localparam int DEF_SETTLE_SAMPLES  = 2400;
  localparam int DEF_OFFSET_TIMEOUT  = 48000;
  localparam int DEF_IMPULSE_TIMEOUT = 48000;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/tick_timer.sv
// tick_timer: saturating sample-tick counter with sync clear and terminal-count hit
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] term,
  output logic         hit
);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clear) count <= '0;
    else if (tick && count != '1) count <= count + 1'b1;
  assign hit = tick && count == term;
endmodule

// File: rtl/calibration_sequencer.sv
// calibration_sequencer: settle / offset / impulse calibration sequence controller
module calibration_sequencer
  import audio_ctrl_pkg::*;
#(
  parameter int SETTLE_SAMPLES  = DEF_SETTLE_SAMPLES,
  parameter int OFFSET_TIMEOUT  = DEF_OFFSET_TIMEOUT,
  parameter int IMPULSE_TIMEOUT = DEF_IMPULSE_TIMEOUT
) (
  input  logic       audio_clk,
  input  logic       rst_in,
  input  logic       audio_trigger,
  input  logic       start_trigger,
  input  logic       abort,
  input  logic       offset_produced,
  input  logic       impulse_recorded,
  output logic       offset_trigger,
  output logic       impulse_trigger,
  output logic       conv_enable,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state_out
);
  localparam int W = $clog2(max3(SETTLE_SAMPLES, OFFSET_TIMEOUT, IMPULSE_TIMEOUT)) + 1;
  localparam logic [W-1:0] T_SET = W'(SETTLE_SAMPLES - 1);
  localparam logic [W-1:0] T_OFF = W'(OFFSET_TIMEOUT - 1);
  localparam logic [W-1:0] T_IMP = W'(IMPULSE_TIMEOUT - 1);
  cal_state_t state, state_next;
  logic [W-1:0] term;
  logic [5:0] out_d;
  logic hit, clear, imp_q, imp_rise;
  // timer restarts on every state change, so each phase counts from zero
  assign clear = state_next != state;
  assign term = (state == OFFSET) ? T_OFF : (state == IMPULSE) ? T_IMP : T_SET;
  // imp_q tracks the level every cycle, so a level high on entry never looks like a rise
  assign imp_rise = impulse_recorded && !imp_q;
  assign state_out = state;
  tick_timer #(.W(W)) u_timer (
    .clk(audio_clk),
    .rst(rst_in),
    .clear(clear),
    .tick(audio_trigger),
    .term(term),
    .hit(hit)
  );
  always_ff @(posedge audio_clk or posedge rst_in)
    if (rst_in) begin
      state <= IDLE;
      imp_q <= 1'b0;
    end else begin
      state <= state_next;
      imp_q <= impulse_recorded;
    end
  always_comb begin
    state_next = state;
    if (abort) state_next = IDLE;
    else
      case (state)
        IDLE:      state_next = start_trigger ? SETTLE_DC : IDLE;
        SETTLE_DC: state_next = hit ? OFFSET : SETTLE_DC;
        OFFSET:    state_next = offset_produced ? SETTLE_IR : hit ? ERROR : OFFSET;
        SETTLE_IR: state_next = hit ? IMPULSE : SETTLE_IR;
        IMPULSE:   state_next = imp_rise ? RUN : hit ? ERROR : IMPULSE;
        RUN:       state_next = start_trigger ? SETTLE_DC : RUN;
        ERROR:     state_next = start_trigger ? SETTLE_DC : ERROR;
        default:   state_next = IDLE;
      endcase
  end
  always_comb
    out_d = {state_next == OFFSET && state != OFFSET,
             state_next == IMPULSE && state != IMPULSE,
             state_next == RUN,
             state_next == RUN,
             state_next inside {SETTLE_DC, OFFSET, SETTLE_IR, IMPULSE},
             state_next == ERROR};
  always_ff @(posedge audio_clk or posedge rst_in)
    if (rst_in) {offset_trigger, impulse_trigger, conv_enable, done, busy, error} <= '0;
    else {offset_trigger, impulse_trigger, conv_enable, done, busy, error} <= out_d;
endmodule

// File: tb/tb_calibration_sequencer.sv
// tb_calibration_sequencer: randomized scenarios checked by an event scoreboard
module tb_calibration_sequencer;
  logic audio_clk = 1'b0;
  logic rst_in, audio_trigger, start_trigger, abort, offset_produced, impulse_recorded;
  logic offset_trigger, impulse_trigger, conv_enable, busy, done, error;
  logic [2:0] state_out;
  typedef struct {logic [8:0] v; int t;} ev_t;
  ev_t q[$];
  ev_t e;
  logic [8:0] cur, prev = '0;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, tk = 0;
  logic ir = 1'b0;
  calibration_sequencer #(.SETTLE_SAMPLES(4), .OFFSET_TIMEOUT(10), .IMPULSE_TIMEOUT(10)) dut (
    .audio_clk(audio_clk),
    .rst_in(rst_in),
    .audio_trigger(audio_trigger),
    .start_trigger(start_trigger),
    .abort(abort),
    .offset_produced(offset_produced),
    .impulse_recorded(impulse_recorded),
    .offset_trigger(offset_trigger),
    .impulse_trigger(impulse_trigger),
    .conv_enable(conv_enable),
    .busy(busy),
    .done(done),
    .error(error),
    .state_out(state_out)
  );
  always #5 audio_clk = ~audio_clk;
  // Expected observable outputs for a state, derived from the status rules
  function automatic logic [8:0] vec(input int s, input logic ot, input logic it);
    return {3'(s), s >= 1 && s <= 4, s == 5, s == 6, s == 5, ot, it};
  endfunction
  function automatic logic [8:0] dut_vec();
    return {state_out, busy, done, error, conv_enable, offset_trigger, impulse_trigger};
  endfunction
  function automatic int nt();
    return tk + ((cyc % 8 == 7) ? 1 : 0);
  endfunction
  task automatic push(input logic [8:0] v, input int t);
    q.push_back('{v: v, t: t});
  endtask
  task automatic clk1(input logic s, input logic o, input logic a);
    @(negedge audio_clk);
    audio_trigger = (cyc % 8 == 7);
    start_trigger = s;
    offset_produced = o;
    abort = a;
    impulse_recorded = ir;
    if (audio_trigger) tk++;
    cyc++;
  endtask
  task automatic adv(input int n);
    repeat (n) clk1(1'b0, 1'b0, 1'b0);
  endtask
  task automatic wait_tk(input int t);
    while (tk < t) clk1(1'b0, 1'b0, 1'b0);
  endtask
  task automatic do_start(output int a);
    int ts;
    ts = nt();
    a = ts + 4;
    push(vec(1, 0, 0), ts);
    push(vec(2, 1, 0), a);
    push(vec(2, 0, 0), a);
    clk1(1'b1, 1'b0, 1'b0);
  endtask
  task automatic offset_phase(input int a, input logic race, output int tp);
    int n, j;
    n = race ? 9 : int'($urandom_range(0, 9));
    j = race ? 7 : int'($urandom_range(1, 7));
    wait_tk(a + n);
    adv(j);
    tp = nt();
    push(vec(3, 0, 0), tp);
    clk1(1'b0, 1'b1, 1'b0);
  endtask
  always @(posedge audio_clk) begin
    #1;
    cur = dut_vec();
    if (cur !== prev) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: got vec=%b at tick %0d, required no change", cur, tk);
      end else begin
        e = q.pop_front();
        if (cur !== e.v || tk != e.t) begin
          n_fail++;
          $display("FAIL event: got vec=%b at tick %0d, required vec=%b at tick %0d", cur, tk, e.v, e.t);
        end
      end
      prev = cur;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
    $fatal(1);
  end
  initial begin
    int a, b, tp, kind;
    rst_in = 1'b1;
    audio_trigger = 1'b0;
    start_trigger = 1'b0;
    abort = 1'b0;
    offset_produced = 1'b0;
    impulse_recorded = 1'b0;
    adv(3);
    n_tests++;
    if (dut_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got vec=%b, required 0", dut_vec());
    end
    rst_in = 1'b0;
    adv(5);
    for (int r = 0; r < 16; r++) begin
      kind = (r < 6) ? r : int'($urandom_range(0, 5));
      ir = (kind == 2);
      adv($urandom_range(2, 9));
      do_start(a);
      if (kind == 1) begin
        push(vec(6, 0, 0), a + 10);
        wait_tk(a + 10);
        adv(3);
        if ($urandom_range(0, 1) == 1) begin
          push(vec(0, 0, 0), nt());
          clk1(1'b0, 1'b0, 1'b1);
          adv(2);
        end
        continue;
      end
      offset_phase(a, kind == 4, tp);
      if (kind == 3) begin
        wait_tk(tp + $urandom_range(0, 2));
        adv($urandom_range(0, 6));
        push(vec(0, 0, 0), nt());
        clk1(1'b1, 1'b0, 1'b1);
        adv(40);
        continue;
      end
      b = tp + 4;
      push(vec(4, 0, 1), b);
      push(vec(4, 0, 0), b);
      if (kind == 2) begin
        push(vec(6, 0, 0), b + 10);
        wait_tk(b + 10);
        adv(3);
      end else if (kind == 5) begin
        wait_tk(b);
        adv($urandom_range(2, 40));
        #1;
        rst_in = 1'b1;
        push(vec(0, 0, 0), tk);
        #1;
        n_tests++;
        if (dut_vec() !== '0) begin
          n_fail++;
          $display("FAIL async_reset: got vec=%b, required 0", dut_vec());
        end
        adv(2);
        rst_in = 1'b0;
        adv(90);
      end else begin
        wait_tk(b + $urandom_range(0, 9));
        adv($urandom_range(1, 7));
        ir = 1'b1;
        push(vec(5, 0, 0), nt());
        clk1(1'b0, 1'b0, 1'b0);
        adv(3);
      end
    end
    adv(20);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: got %0d outstanding, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
